axi_arbiter_rr: RTL and testbench

AXI_ARBITER_RR -- requirements
Module: axi_arbiter_rr

---
 rtl/axi_arb_pkg.sv | 34 +++
 rtl/axi_arb_rr_pick.sv | 51 +++++
 rtl/axi_arbiter_rr.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_arbiter_rr.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the round-robin AXI channel arbiter.
//   NUM_M_MAX    : largest supported master count
//   grant_vec_t  : grant / request vector sized for NUM_M_MAX masters
//   w_state_t    : write-channel FSM states
//   r_state_t    : read-channel FSM states
//   onehot_of()  : index -> one-hot grant vector helper
// -----------------------------------------------------------------------------
package axi_arb_pkg;

    localparam int NUM_M_MAX = 8;

    typedef logic [NUM_M_MAX-1:0] grant_vec_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    // One-hot vector with bit 'idx' set; callers narrow it to NUM_M bits.
    function automatic grant_vec_t onehot_of(input logic [$clog2(NUM_M_MAX)-1:0] idx);
        return grant_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/axi_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// axi_arb_rr_pick
// Combinational round-robin selector. Searches the request vector starting at
// (ptr+1) mod NUM_M and wrapping upward; the first set bit wins.
// Ports:
//   req         [NUM_M-1:0]  request bits, bit i = master i
//   ptr         [IDX-1:0]    index of the most recently granted master
//   pick_onehot [NUM_M-1:0]  one-hot winner, zero when no request
//   pick_idx    [IDX-1:0]    binary index of the winner (0 when none)
//   pick_valid               at least one request present
// -----------------------------------------------------------------------------
module axi_arb_rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM_M = 4
) (
    input  logic [NUM_M-1:0]         req,
    input  logic [$clog2(NUM_M)-1:0] ptr,
    output logic [NUM_M-1:0]         pick_onehot,
    output logic [$clog2(NUM_M)-1:0] pick_idx,
    output logic                     pick_valid
);

    localparam int IDX_W = $clog2(NUM_M);

    // cand_idx[k] is the master examined at search position k (k=0 first).
    logic [IDX_W-1:0] cand_idx [NUM_M];

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(ptr) + gi + 1) % NUM_M);
        end
    endgenerate

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        // Walk from the farthest candidate toward the nearest so that the
        // nearest requester after ptr is the final (winning) assignment.
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
        pick_onehot = pick_valid
                    ? NUM_M'(onehot_of($clog2(NUM_M_MAX)'(pick_idx)))
                    : '0;
    end

endmodule

// File: rtl/axi_arbiter_rr.sv
// -----------------------------------------------------------------------------
// axi_arbiter_rr
// Round-robin arbiter for a shared AXI bus with independent write and read
// arbitration. Each channel runs its own FSM and pointer; a grant is taken in
// IDLE, held constant for the whole transaction and dropped the cycle after
// the final handshake, which guarantees one IDLE cycle between transactions.
//
// Parameters:
//   NUM_M    number of masters (2..8)
//   TIMEOUT  watchdog limit in cycles (16..65535), only with AXI_ARB_TIMEOUT_EN
//
// Build option:
//   `define AXI_ARB_TIMEOUT_EN  adds a per-channel watchdog that aborts a
//                               transaction still open TIMEOUT cycles after
//                               grant and pulses wr_timeout / rd_timeout.
//                               Undefined: no counters, timeout outputs are 0.
//
// Ports:
//   ACLK, ARESET                   clock, synchronous active-high reset
//   m_AWVALID/m_WVALID/m_WLAST/
//   m_BREADY/m_ARVALID [NUM_M]     per-master request / handshake bits
//   s_AWREADY/s_WREADY/s_BVALID/
//   s_ARREADY/s_RVALID/s_RLAST/
//   s_RREADY                       muxed shared-bus handshake bits
//   wgrnt, rgrnt [NUM_M]           registered one-hot (or zero) grants
//   wr_busy, rd_busy               channel FSM not IDLE
//   wr_timeout, rd_timeout         one-cycle watchdog abort pulse
// -----------------------------------------------------------------------------
module axi_arbiter_rr
    import axi_arb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [NUM_M-1:0] m_AWVALID,
    input  logic [NUM_M-1:0] m_WVALID,
    input  logic [NUM_M-1:0] m_WLAST,
    input  logic [NUM_M-1:0] m_BREADY,
    input  logic [NUM_M-1:0] m_ARVALID,
    input  logic             s_AWREADY,
    input  logic             s_WREADY,
    input  logic             s_BVALID,
    input  logic             s_ARREADY,
    input  logic             s_RVALID,
    input  logic             s_RLAST,
    input  logic             s_RREADY,
    output logic [NUM_M-1:0] wgrnt,
    output logic [NUM_M-1:0] rgrnt,
    output logic             wr_busy,
    output logic             rd_busy,
    output logic             wr_timeout,
    output logic             rd_timeout
);

    localparam int               IDX_W     = $clog2(NUM_M);
    // Pointer resets to the last master so that master 0 wins first.
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_M - 1);

    // Elaboration-time guard on the parameter ranges.
    if (NUM_M < 2 || NUM_M > NUM_M_MAX) begin : g_bad_num_m
        $error("axi_arbiter_rr: NUM_M must be in 2..%0d", NUM_M_MAX);
    end
    if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("axi_arbiter_rr: TIMEOUT must be in 16..65535");
    end

    // -------------------------------------------------------------------------
    // Channel state
    // -------------------------------------------------------------------------
    w_state_t         w_state_q, w_state_d;
    r_state_t         r_state_q, r_state_d;
    logic [NUM_M-1:0] wgrnt_q, wgrnt_d;
    logic [NUM_M-1:0] rgrnt_q, rgrnt_d;
    logic [IDX_W-1:0] wptr_q, wptr_d;
    logic [IDX_W-1:0] rptr_q, rptr_d;

    // Final handshake seen this cycle / watchdog expiring this cycle.
    logic w_done, r_done;
    logic w_expire, r_expire;

    // -------------------------------------------------------------------------
    // Round-robin selectors, one per channel
    // -------------------------------------------------------------------------
    logic [NUM_M-1:0] w_pick_onehot, r_pick_onehot;
    logic [IDX_W-1:0] w_pick_idx, r_pick_idx;
    logic             w_pick_valid, r_pick_valid;

    axi_arb_rr_pick #(.NUM_M(NUM_M)) u_w_pick (
        .req         (m_AWVALID),
        .ptr         (wptr_q),
        .pick_onehot (w_pick_onehot),
        .pick_idx    (w_pick_idx),
        .pick_valid  (w_pick_valid)
    );

    axi_arb_rr_pick #(.NUM_M(NUM_M)) u_r_pick (
        .req         (m_ARVALID),
        .ptr         (rptr_q),
        .pick_onehot (r_pick_onehot),
        .pick_idx    (r_pick_idx),
        .pick_valid  (r_pick_valid)
    );

    // -------------------------------------------------------------------------
    // Write FSM. Master-side bits are always masked with the held grant so
    // that non-granted masters cannot advance the channel.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        wgrnt_d   = wgrnt_q;
        wptr_d    = wptr_q;
        w_done    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (w_pick_valid) begin
                    w_state_d = W_ADDR;
                    wgrnt_d   = w_pick_onehot;
                    wptr_d    = w_pick_idx;
                end
            end
            W_ADDR: begin
                if (|(m_AWVALID & wgrnt_q) && s_AWREADY) begin
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // WLAST only counts here, so a WLAST riding on the AW
                // handshake cycle is ignored.
                if (|(m_WVALID & m_WLAST & wgrnt_q) && s_WREADY) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_BVALID && |(m_BREADY & wgrnt_q)) begin
                    w_done = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (w_done || w_expire) begin
            w_state_d = W_IDLE;
            wgrnt_d   = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Read FSM. The R channel is already muxed, so completion needs no mask.
    // -------------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        rgrnt_d   = rgrnt_q;
        rptr_d    = rptr_q;
        r_done    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (r_pick_valid) begin
                    r_state_d = R_ADDR;
                    rgrnt_d   = r_pick_onehot;
                    rptr_d    = r_pick_idx;
                end
            end
            R_ADDR: begin
                if (|(m_ARVALID & rgrnt_q) && s_ARREADY) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_RVALID && s_RREADY && s_RLAST) begin
                    r_done = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_done || r_expire) begin
            r_state_d = R_IDLE;
            rgrnt_d   = '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wgrnt_q   <= '0;
            rgrnt_q   <= '0;
            wptr_q    <= PTR_RESET;
            rptr_q    <= PTR_RESET;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wgrnt_q   <= wgrnt_d;
            rgrnt_q   <= rgrnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
`ifdef AXI_ARB_TIMEOUT_EN
    localparam int                WDOG_W    = 16;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] wcnt_q, wcnt_d;
    logic [WDOG_W-1:0] rcnt_q, rcnt_d;
    logic              wr_timeout_q, wr_timeout_d;
    logic              rd_timeout_q, rd_timeout_d;

    // Counters sit at zero in IDLE, so the first granted cycle counts 0 and
    // expiry lands TIMEOUT cycles after the grant appears. A completion in
    // the expiry cycle wins and suppresses the pulse.
    always_comb begin
        wcnt_d       = (w_state_q == W_IDLE) ? '0 : wcnt_q + WDOG_W'(1);
        rcnt_d       = (r_state_q == R_IDLE) ? '0 : rcnt_q + WDOG_W'(1);
        w_expire     = (w_state_q != W_IDLE) && (wcnt_q == WDOG_LAST);
        r_expire     = (r_state_q != R_IDLE) && (rcnt_q == WDOG_LAST);
        wr_timeout_d = w_expire && !w_done;
        rd_timeout_d = r_expire && !r_done;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            wr_timeout_q <= 1'b0;
            rd_timeout_q <= 1'b0;
        end else begin
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            wr_timeout_q <= wr_timeout_d;
            rd_timeout_q <= rd_timeout_d;
        end
    end

    assign wr_timeout = wr_timeout_q;
    assign rd_timeout = rd_timeout_q;
`else
    assign w_expire   = 1'b0;
    assign r_expire   = 1'b0;
    assign wr_timeout = 1'b0;
    assign rd_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign wgrnt   = wgrnt_q;
    assign rgrnt   = rgrnt_q;
    assign wr_busy = (w_state_q != W_IDLE);
    assign rd_busy = (r_state_q != R_IDLE);

endmodule

// File: tb/tb_axi_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_axi_arbiter_rr
// Directed bench for axi_arbiter_rr (NUM_M=4, TIMEOUT=16). Each stimulus row
// pushes the outputs expected in the current cycle into a scoreboard queue,
// drives that cycle's inputs and advances one clock. A separate monitor pops
// and compares on every falling edge.
// Row arguments: name, ARESET, m_AWVALID, m_WVALID, m_WLAST, m_BREADY,
//   m_ARVALID, {s_AWREADY,s_WREADY,s_BVALID,s_ARREADY,s_RVALID,s_RLAST,
//   s_RREADY}, expected wgrnt, expected rgrnt,
//   expected {wr_busy,rd_busy,wr_timeout,rd_timeout}.
// -----------------------------------------------------------------------------
module tb_axi_arbiter_rr;

    localparam int NUM_M   = 4;
    localparam int TIMEOUT = 16;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [NUM_M-1:0] m_AWVALID, m_WVALID, m_WLAST, m_BREADY, m_ARVALID;
    logic             s_AWREADY, s_WREADY, s_BVALID, s_ARREADY;
    logic             s_RVALID, s_RLAST, s_RREADY;
    logic [NUM_M-1:0] wgrnt, rgrnt;
    logic             wr_busy, rd_busy, wr_timeout, rd_timeout;

    always #5 ACLK = ~ACLK;

    axi_arbiter_rr #(.NUM_M(NUM_M), .TIMEOUT(TIMEOUT)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .m_AWVALID  (m_AWVALID),
        .m_WVALID   (m_WVALID),
        .m_WLAST    (m_WLAST),
        .m_BREADY   (m_BREADY),
        .m_ARVALID  (m_ARVALID),
        .s_AWREADY  (s_AWREADY),
        .s_WREADY   (s_WREADY),
        .s_BVALID   (s_BVALID),
        .s_ARREADY  (s_ARREADY),
        .s_RVALID   (s_RVALID),
        .s_RLAST    (s_RLAST),
        .s_RREADY   (s_RREADY),
        .wgrnt      (wgrnt),
        .rgrnt      (rgrnt),
        .wr_busy    (wr_busy),
        .rd_busy    (rd_busy),
        .wr_timeout (wr_timeout),
        .rd_timeout (rd_timeout)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [11:0] val;   // {wgrnt, rgrnt, wr_busy, rd_busy, wr_timeout, rd_timeout}
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always @(posedge ACLK) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle.
    always @(negedge ACLK) begin
        logic [11:0] got;
        exp_t        e;
        got = {wgrnt, rgrnt, wr_busy, rd_busy, wr_timeout, rd_timeout};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                n_errors++;
                $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d",
                         e.name, e.cyc, cyc);
            end else if (got !== e.val) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got wgrnt=%b rgrnt=%b busy(w,r)=%b timeout(w,r)=%b, expected wgrnt=%b rgrnt=%b busy(w,r)=%b timeout(w,r)=%b",
                         e.name, cyc, got[11:8], got[7:4], got[3:2], got[1:0],
                         e.val[11:8], e.val[7:4], e.val[3:2], e.val[1:0]);
            end else begin
                $display("ok   %s cycle %0d: wgrnt=%b rgrnt=%b busy=%b timeout=%b",
                         e.name, cyc, got[11:8], got[7:4], got[3:2], got[1:0]);
            end
        end
    end

    task automatic v(input string name, input logic arst,
                     input logic [3:0] awv, input logic [3:0] wv, input logic [3:0] wl,
                     input logic [3:0] bry, input logic [3:0] arv, input logic [6:0] s,
                     input logic [3:0] ewg, input logic [3:0] erg, input logic [3:0] est);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.val  = {ewg, erg, est};
        sb.push_back(e);
        ARESET    = arst;
        m_AWVALID = awv;
        m_WVALID  = wv;
        m_WLAST   = wl;
        m_BREADY  = bry;
        m_ARVALID = arv;
        {s_AWREADY, s_WREADY, s_BVALID, s_ARREADY, s_RVALID, s_RLAST, s_RREADY} = s;
        @(posedge ACLK);
        #1;
    endtask

    // Absolute time bound; the stimulus itself never waits on the DUT.
    initial begin
        #200000;
        $display("FAIL global_timeout: run did not complete, got no end, required end before 200000");
        $fatal(1, "time limit");
    end

    initial begin
        ARESET    = 1'b1;
        m_AWVALID = '0; m_WVALID = '0; m_WLAST = '0; m_BREADY = '0; m_ARVALID = '0;
        {s_AWREADY, s_WREADY, s_BVALID, s_ARREADY, s_RVALID, s_RLAST, s_RREADY} = '0;
        repeat (2) @(posedge ACLK);
        #1;

        // --- Round robin over all four writers, one IDLE cycle between ---
        v("a_reset_state", 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 7'b1110000, 4'h0, 4'h0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            v($sformatf("a_g%0d_addr", k), 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 7'b1110000, seq[k], 4'h0, 4'b1000);
            v($sformatf("a_g%0d_data", k), 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 7'b1110000, seq[k], 4'h0, 4'b1000);
            v($sformatf("a_g%0d_resp", k), 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 7'b1110000, seq[k], 4'h0, 4'b1000);
            if (k == 4)
                v($sformatf("a_g%0d_idle", k), 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h0, 4'h0, 4'b0000);
            else
                v($sformatf("a_g%0d_idle", k), 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 7'b1110000, 4'h0, 4'h0, 4'b0000);
        end

        // --- Master 2 write: AW at cycle 3, 4 beats, B at cycle 10 ---
        v("b_c0_req",    0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h0, 4'h0, 4'b0000);
        v("b_c1_awwait", 0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h4, 4'h0, 4'b1000);
        v("b_c2_awwait", 0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h4, 4'h0, 4'b1000);
        v("b_c3_aw_wl",  0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 7'b1100000, 4'h4, 4'h0, 4'b1000);
        v("b_c4_beat1",  0, 4'h1, 4'h4, 4'h0, 4'h0, 4'h0, 7'b0100000, 4'h4, 4'h0, 4'b1000);
        v("b_c5_beat2",  0, 4'h1, 4'hC, 4'h8, 4'h0, 4'h0, 7'b0100000, 4'h4, 4'h0, 4'b1000);
        v("b_c6_beat3",  0, 4'h1, 4'h4, 4'h0, 4'h0, 4'h0, 7'b0100000, 4'h4, 4'h0, 4'b1000);
        v("b_c7_beat4",  0, 4'h1, 4'h4, 4'h4, 4'h0, 4'h0, 7'b0100000, 4'h4, 4'h0, 4'b1000);
        v("b_c8_bother", 0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 7'b0010000, 4'h4, 4'h0, 4'b1000);
        v("b_c9_bwait",  0, 4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 7'b0000000, 4'h4, 4'h0, 4'b1000);
        v("b_c10_b",     0, 4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 7'b0010000, 4'h4, 4'h0, 4'b1000);
        v("b_c11_idle",  0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h0, 4'h0, 4'b0000);

        // --- Pending master 0 granted; master 3 noise in W_DATA; reset ---
        v("c_m0_addr",     0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 7'b1000000, 4'h1, 4'h0, 4'b1000);
        v("c_m3_noise_a",  0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 7'b0100000, 4'h1, 4'h0, 4'b1000);
        v("c_m3_noise_b",  0, 4'h0, 4'h0, 4'h8, 4'hF, 4'h0, 7'b0110000, 4'h1, 4'h0, 4'b1000);
        v("c_m3_noise_c",  0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 7'b0100000, 4'h1, 4'h0, 4'b1000);
        v("c_reset_wdata", 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h1, 4'h0, 4'b1000);
        v("c_after_reset", 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h0, 4'h0, 4'b0000);
        v("c_m3_addr",     0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 7'b1000000, 4'h8, 4'h0, 4'b1000);
        v("c_m3_data",     0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 7'b0100000, 4'h8, 4'h0, 4'b1000);
        v("c_m3_resp",     0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 7'b0010000, 4'h8, 4'h0, 4'b1000);

        // --- Master 1 holds write and read grants concurrently ---
        v("d_idle_req",    0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 7'b0000000, 4'h0, 4'h0, 4'b0000);
        v("d_both_addr",   0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 7'b1001000, 4'h2, 4'h2, 4'b1100);
        v("d_beat_rbeat",  0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 7'b0100101, 4'h2, 4'h2, 4'b1100);
        v("d_beat_rlast",  0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 7'b0100111, 4'h2, 4'h2, 4'b1100);
        v("d_wlast",       0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 7'b0100000, 4'h2, 4'h0, 4'b1000);
        v("d_bresp",       0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 7'b0010000, 4'h2, 4'h0, 4'b1000);

        // --- Read granted to master 2 then starved of RVALID ---
        v("e_idle_req",    0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 7'b0000000, 4'h0, 4'h0, 4'b0000);
        v("e_grant",       0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 7'b0001000, 4'h0, 4'h4, 4'b0100);
        for (int i = 1; i < TIMEOUT; i++) begin
            v($sformatf("e_hold%0d", i), 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h0, 4'h4, 4'b0100);
        end
`ifdef AXI_ARB_TIMEOUT_EN
        v("e_timeout",     0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 7'b0000000, 4'h0, 4'h0, 4'b0001);
`else
        v("e_no_timeout",  0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000111, 4'h0, 4'h4, 4'b0100);
        v("e_idle_req2",   0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 7'b0000000, 4'h0, 4'h0, 4'b0000);
`endif
        // Pointer advanced past master 2 either way, so master 3 is next.
        v("f_regrant",     0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 7'b0001000, 4'h0, 4'h8, 4'b0100);
        v("f_rlast",       0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000111, 4'h0, 4'h8, 4'b0100);
        v("f_idle",        0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 7'b0000000, 4'h0, 4'h0, 4'b0000);

        @(negedge ACLK);
        #1;
        if (sb.size() != 0) begin
            n_errors += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked expectations, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
